// File: rtl/baccarat_statemachine.sv
// Punto Banco table controller: deals four cards, applies the third-card
// drawing rules to the datapath scores, then lights the winner LEDs.
// Optional macro BACCARAT_STATE_DBG_EN exposes the state register on state_dbg.
module baccarat_statemachine (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef BACCARAT_STATE_DBG_EN
  ,
  output logic [2:0] state_dbg
`endif
);

  typedef enum logic [2:0] {
    DEAL_P1   = 3'd0,
    DEAL_D1   = 3'd1,
    DEAL_P2   = 3'd2,
    DEAL_D2   = 3'd3,
    DECIDE_P3 = 3'd4,
    DECIDE_D3 = 3'd5,
    RESULT    = 3'd6
  } state_t;

  state_t state_q;
  state_t state_d;

  // Face cards and tens count as zero; rank 0 (no card) is also zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if (rank >= 4'd10) begin
      card_value = 4'd0;
    end else begin
      card_value = rank;
    end
  endfunction

  function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] v);
    case (d)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (v != 4'd8);
      4'd4:             banker_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             banker_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             banker_draws = (v >= 4'd6) && (v <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  endfunction

  // State register with synchronous reset back to the first deal.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_q <= DEAL_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe/light decode from current state and scores.
  always_comb begin
    state_d          = state_q;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state_q)
      DEAL_P1: begin
        load_pcard1 = 1'b1;
        state_d     = DEAL_D1;
      end
      DEAL_D1: begin
        load_dcard1 = 1'b1;
        state_d     = DEAL_P2;
      end
      DEAL_P2: begin
        load_pcard2 = 1'b1;
        state_d     = DEAL_D2;
      end
      DEAL_D2: begin
        load_dcard2 = 1'b1;
        state_d     = DECIDE_P3;
      end
      DECIDE_P3: begin
        // A natural on either side ends the hand without further cards.
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          state_d = RESULT;
        end else if (pscore <= 4'd5) begin
          load_pcard3 = 1'b1;
          state_d     = DECIDE_D3;
        end else begin
          load_dcard3 = (dscore <= 4'd5);
          state_d     = RESULT;
        end
      end
      DECIDE_D3: begin
        load_dcard3 = banker_draws(dscore, card_value(pcard3));
        state_d     = RESULT;
      end
      RESULT: begin
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
        state_d          = RESULT;
      end
      default: begin
        state_d = DEAL_P1;
      end
    endcase
  end

`ifdef BACCARAT_STATE_DBG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_baccarat_statemachine.sv
// Self-checking bench: a game-position model checked every cycle, plus
// directed games with hand-computed literal expectations.
module tb_baccarat_statemachine;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
`ifdef BACCARAT_STATE_DBG_EN
  logic [2:0] state_dbg;
`endif

  int total = 0;
  int bad   = 0;

  baccarat_statemachine dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
`ifdef BACCARAT_STATE_DBG_EN
    ,
    .state_dbg        (state_dbg)
`endif
  );

  // Output vector: {lp1, ld1, lp2, ld2, lp3, ld3, player_win, dealer_win}
  logic [7:0] outv;
  assign outv = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                 load_pcard3, load_dcard3, player_win_light, dealer_win_light};

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  // Model: the game position is 0-3 for the four deals, 4 = third-card
  // decision, 5 = banker's reply to a player draw, 6 = hand finished.
  int m_pos   = 0;
  bit m_valid = 1'b0;

  // Banker draw masks indexed by banker score, bit v = player third card value.
  function automatic logic [9:0] banker_mask(input int d);
    case (d)
      0, 1, 2: return 10'b11_1111_1111;
      3:       return 10'b10_1111_1111;
      4:       return 10'b00_1111_1100;
      5:       return 10'b00_1111_0000;
      6:       return 10'b00_1100_0000;
      default: return 10'b00_0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] model_out(input int pos, input int p, input int d, input int c);
    logic [9:0] m;
    int v;
    if (pos < 4) return 8'b1000_0000 >> pos;
    if (pos == 4) begin
      if (p >= 8 || d >= 8) return 8'b0;
      if (p <= 5) return 8'b0000_1000;
      return (d <= 5) ? 8'b0000_0100 : 8'b0;
    end
    if (pos == 5) begin
      v = (c >= 10) ? 0 : c;
      m = banker_mask(d);
      return m[v] ? 8'b0000_0100 : 8'b0;
    end
    return {6'b0, (p >= d) ? 1'b1 : 1'b0, (d >= p) ? 1'b1 : 1'b0};
  endfunction

  function automatic int model_next(input int pos, input int p, input int d);
    if (pos < 4) return pos + 1;
    if (pos == 4) return (p < 8 && d < 8 && p <= 5) ? 5 : 6;
    return 6;
  endfunction

  // Advance the model on each rising edge using the inputs seen there.
  always @(posedge slow_clock) begin
    if (resetb) begin
      m_pos   <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      m_pos <= model_next(m_pos, pscore, dscore);
    end
  end

  // Every-cycle comparison away from the active edge.
  always @(negedge slow_clock) begin
    logic [7:0] exp;
    if (m_valid) begin
      exp = model_out(m_pos, pscore, dscore, pcard3);
      total++;
      if (outv !== exp) begin
        bad++;
        $display("FAIL model t=%0t pos=%0d p=%0d d=%0d c=%0d got=%b want=%b",
                 $time, m_pos, pscore, dscore, pcard3, outv, exp);
      end
    end
  end

  task automatic step(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c);
    pscore = p; dscore = d; pcard3 = c;
    @(posedge slow_clock); #1;
  endtask

  task automatic step_lit(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c,
                          input logic [7:0] want, input string name);
    pscore = p; dscore = d; pcard3 = c;
    @(negedge slow_clock); #1;
    total++;
    if (outv !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, outv, want);
    end
    @(posedge slow_clock); #1;
  endtask

  task automatic new_game();
    resetb = 1'b1;
    @(posedge slow_clock); #1;
    resetb = 1'b0;
    step(4'd0, 4'd0, 4'd0);
    step(4'd0, 4'd0, 4'd0);
    step(4'd0, 4'd0, 4'd0);
    step(4'd0, 4'd0, 4'd0);
  endtask

  // Reach the banker decision with a given banker score and player card.
  task automatic banker_case(input logic [3:0] d, input logic [3:0] c, input logic want, input string name);
    new_game();
    step_lit(4'd0, d, 4'd0, 8'b0000_1000, "p3_draw");
    step_lit(4'd0, d, c, {5'b0, want, 2'b0}, name);
  endtask

  initial begin
    resetb = 1'b1; pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    @(posedge slow_clock); #1;
    resetb = 1'b0;
    step_lit(4'd0, 4'd0, 4'd0, 8'b1000_0000, "deal_p1");
    step_lit(4'd0, 4'd0, 4'd0, 8'b0100_0000, "deal_d1");
    step_lit(4'd0, 4'd0, 4'd0, 8'b0010_0000, "deal_p2");
    step_lit(4'd0, 4'd0, 4'd0, 8'b0001_0000, "deal_d2");
    step_lit(4'd8, 4'd5, 4'd0, 8'b0000_0000, "natural_p3");
    step_lit(4'd8, 4'd5, 4'd0, 8'b0000_0010, "natural_pwin");
    step_lit(4'd9, 4'd9, 4'd0, 8'b0000_0011, "tie_99");
    step_lit(4'd3, 4'd4, 4'd0, 8'b0000_0001, "result_hold");

    new_game();
    step_lit(4'd4, 4'd6, 4'd0, 8'b0000_1000, "p3_draw_46");
    step_lit(4'd4, 4'd6, 4'd7, 8'b0000_0100, "d3_6_v7");
    step_lit(4'd1, 4'd5, 4'd7, 8'b0000_0001, "dealer_wins");

    new_game();
    step_lit(4'd4, 4'd6, 4'd0, 8'b0000_1000, "p3_draw_46b");
    step_lit(4'd4, 4'd6, 4'd3, 8'b0000_0000, "d3_6_v3");

    banker_case(4'd3, 4'd8,  1'b0, "b3_v8");
    banker_case(4'd3, 4'd7,  1'b1, "b3_v7");
    banker_case(4'd4, 4'd8,  1'b0, "b4_v8");
    banker_case(4'd4, 4'd2,  1'b1, "b4_v2");
    banker_case(4'd0, 4'd5,  1'b1, "b0_v5");
    banker_case(4'd1, 4'd13, 1'b1, "b1_k");
    banker_case(4'd2, 4'd9,  1'b1, "b2_v9");
    banker_case(4'd7, 4'd7,  1'b0, "b7_v7");
    banker_case(4'd3, 4'd12, 1'b1, "b3_q");
    banker_case(4'd4, 4'd12, 1'b0, "b4_q");
    banker_case(4'd5, 4'd4,  1'b1, "b5_v4");
    banker_case(4'd6, 4'd11, 1'b0, "b6_j");
    banker_case(4'd6, 4'd6,  1'b1, "b6_v6");

    new_game();
    step_lit(4'd7, 4'd2, 4'd0, 8'b0000_0100, "stand_b2");
    step_lit(4'd7, 4'd7, 4'd0, 8'b0000_0011, "tie_77");

    new_game();
    step_lit(4'd7, 4'd6, 4'd0, 8'b0000_0000, "stand_b6");
    step_lit(4'd7, 4'd6, 4'd0, 8'b0000_0010, "pwin_76");

    // Reset during the banker decision.
    new_game();
    step(4'd2, 4'd1, 4'd0);
    resetb = 1'b1;
    step(4'd2, 4'd1, 4'd5);
    resetb = 1'b0;
    step_lit(4'd2, 4'd1, 4'd5, 8'b1000_0000, "rst_from_d3");

    // Reset while the result is showing.
    new_game();
    step(4'd9, 4'd1, 4'd0);
    step_lit(4'd9, 4'd1, 4'd0, 8'b0000_0010, "pre_rst_result");
    resetb = 1'b1;
    step(4'd9, 4'd1, 4'd0);
    resetb = 1'b0;
    step_lit(4'd9, 4'd1, 4'd0, 8'b1000_0000, "rst_from_result");
    step_lit(4'd9, 4'd1, 4'd0, 8'b0100_0000, "after_rst_d1");

    // Exhaustive banker sweep checked by the model.
    for (int d = 0; d < 8; d++) begin
      for (int r = 0; r < 14; r++) begin
        new_game();
        step(4'd0, 4'(d), 4'd0);
        step(4'd0, 4'(d), 4'(r));
        step(4'd0, 4'(d), 4'(r));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baccarat_statemachine.md
Name: baccarat_statemachine

Overview:
Control FSM for the Punto Banco (baccarat) card table. It sequences the deal of up to three player and three dealer cards by pulsing load strobes to the card datapath. It applies the standard drawing rules to the running scores fed back from that datapath. It then lights the player/dealer win LEDs (both lit for a tie). It sits between the slow game clock and the card/score datapath.

Parameters:
None.

Ports:
- slow_clock  input  1  Game clock; all state changes occur on its rising edge.
- resetb  input  1  Synchronous, active-high reset.
- pscore  input  4  Player hand score 0-9, from the datapath.
- dscore  input  4  Dealer hand score 0-9, from the datapath.
- pcard3  input  4  Player third-card rank: 0 means none, 1-13 is a rank. Ranks 10-13 count as value 0.
- load_pcard1, load_pcard2, load_pcard3  output  1 each  Player card load strobes.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  Dealer card load strobes.
- player_win_light  output  1  Player wins, or tie.
- dealer_win_light  output  1  Dealer wins, or tie.

Behaviour:
- States: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DECIDE_P3, DECIDE_D3, RESULT. Use a 3-bit state register.
- Reset: if resetb=1 at a rising edge, the state becomes DEAL_P1. Reset takes priority from any state, including mid-game.
- While in DEAL_P1, load_pcard1=1; all other strobes and both lights are 0.
- Fixed sequence, one cycle per state, with one strobe high in each:
  - DEAL_P1 -> DEAL_D1 (load_dcard1)
  - DEAL_D1 -> DEAL_P2 (load_pcard2)
  - DEAL_P2 -> DEAL_D2 (load_dcard2)
  - DEAL_D2 -> DECIDE_P3
- Outputs are combinational from the current state plus the current inputs. No strobe is high in any state other than the one named below.
- DECIDE_P3 evaluates pscore/dscore combinationally:
  - Natural (pscore>=8 or dscore>=8): no strobe; next state RESULT.
  - Otherwise, if pscore<=5: load_pcard3=1; next state DECIDE_D3.
  - Otherwise (pscore 6-7): if dscore<=5, load_dcard3=1; next state RESULT in both cases.
- DECIDE_D3 banker rule. v is the value of pcard3 (rank mod 10; 10-13 -> 0). load_dcard3=1 when:
  - dscore 0-2: always.
  - dscore 3: v!=8.
  - dscore 4: v in 2..7.
  - dscore 5: v in 4..7.
  - dscore 6: v in 6..7.
  - dscore 7: never.
  - Next state is RESULT.
- RESULT lights, computed combinationally from the current scores:
  - player_win_light = (pscore>=dscore).
  - dealer_win_light = (dscore>=pscore).
  - A tie lights both.
- RESULT holds until reset. Both lights are 0 in all other states.
- The strobe is asserted for the whole cycle. The datapath captures the card on the rising edge that leaves the state. New scores are therefore visible from the next state onward.
- Scores above 9 are not expected and are compared as unsigned values.

Optional Feature:
- Macro: BACCARAT_STATE_DBG_EN.
- Defined: adds an output port state_dbg [2:0] carrying the state register. Encoding: DEAL_P1=0, DEAL_D1=1, DEAL_P2=2, DEAL_D2=3, DECIDE_P3=4, DECIDE_D3=5, RESULT=6.
- Undefined: the port is absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then 4 cycles: load_pcard1, load_dcard1, load_pcard2, load_dcard2 are each high for exactly one cycle, in that order.
- pscore=8, dscore=5 in DECIDE_P3 -> no strobes; in RESULT, player_win_light=1, dealer_win_light=0. With pscore=9, dscore=9 -> both lights=1.
- pscore=4, dscore=6 -> load_pcard3=1.
  - Then pcard3=7: load_dcard3=1.
  - Then pcard3=3: load_dcard3=0.
  - With pscore=1 and dscore=5 afterwards -> dealer_win_light only.
- Banker table sweep in DECIDE_D3, all must hold:
  - dscore=3: v=8 -> 0; v=7 -> 1.
  - dscore=4: v=8 -> 0.
  - dscore=0/1/2 -> 1 for any v.
  - dscore=7 -> 0.
  - pcard3=12 treated as v=0.
- pscore=7, dscore=2 -> load_pcard3=0, load_dcard3=1. Then dscore=7 -> tie, both lights. With dscore=6 instead -> no strobe, player wins.
- Assert resetb mid-game (in DECIDE_D3 or RESULT) -> next cycle is DEAL_P1 with load_pcard1=1 and both lights 0.
